// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction fetch and data access.
// An in-order ID FIFO routes each downstream response back to the requester that issued it.
module sram_arbiter #(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_err
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    // Grant / ID encoding: 0 = inst, 1 = data
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t        state;
    lock_state_t        state_nxt;
    logic               lock_id;
    logic               lock_id_nxt;
    logic               last_grant;

    logic [OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic               grant;
    logic               granted_req;
    logic               full;
    logic               empty;
    logic               handshake;
    logic               pop;
    logic               head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // Lock holds the previous grant; otherwise round-robin on conflict
    always_comb begin
        grant = ID_INST;
        if (state == ST_LOCKED) begin
            grant = lock_id;
        end else if (inst_req && data_req) begin
            grant = ~last_grant;
        end else if (data_req) begin
            grant = ID_DATA;
        end
    end

    assign granted_req = (grant == ID_DATA) ? data_req : inst_req;

    assign mem_req   = resetn & ~full & granted_req;
    assign mem_wr    = (grant == ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (grant == ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (grant == ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (grant == ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (grant == ID_DATA) ? data_wdata : inst_wdata;

    assign handshake    = mem_req & mem_addr_ok;
    assign inst_addr_ok = handshake & (grant == ID_INST);
    assign data_addr_ok = handshake & (grant == ID_DATA);

    // Responses return in issue order, so the FIFO head names the owner
    assign pop          = resetn & mem_data_ok & ~empty;
    assign head         = id_fifo[rd_ptr];
    assign inst_data_ok = pop & (head == ID_INST);
    assign data_data_ok = pop & (head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_OPEN;
            lock_id <= ID_INST;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    // A stalled request locks the grant until accepted or abandoned
    always_comb begin
        state_nxt   = state;
        lock_id_nxt = lock_id;
        if (handshake) begin
            state_nxt = ST_OPEN;
        end else if (mem_req) begin
            state_nxt   = ST_LOCKED;
            lock_id_nxt = grant;
        end else if ((state == ST_LOCKED) && !granted_req) begin
            state_nxt = ST_OPEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= ID_INST;
            arb_err    <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr     <= ptr_inc(wr_ptr);
                last_grant <= grant;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({handshake, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (mem_data_ok && empty) begin
                arb_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset; entries are only read once written
    always_ff @(posedge clk) begin
        if (handshake) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed test of sram_arbiter: routing, round-robin, locking, full stall, reset and error flag.
module tb_sram_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_err;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; new inputs are applied 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 32'h1c00_0000; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 32'h8000_0000; data_wdata = 32'h0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;

        // Reset: handshakes suppressed, error flag clear
        settle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        cyc();
        chk("rst_arb_err", 32'(arb_err), 32'd0);
        inst_req = 1'b0; mem_data_ok = 1'b0;
        cyc();
        resetn = 1'b1;

        // Inst-only reads with a one-cycle memory
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        settle();
        chk("t1_c0_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_c0_mem_addr", mem_addr, 32'h1c00_0000);
        chk("t1_c0_data_addr_ok", 32'(data_addr_ok), 32'd0);
        cyc();
        inst_addr = 32'h1c00_0004; mem_data_ok = 1'b1; mem_rdata = 32'ha000_0000;
        settle();
        chk("t1_c1_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_c1_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_c1_rdata", inst_rdata, 32'ha000_0000);
        chk("t1_c1_ddata_ok", 32'(data_data_ok), 32'd0);
        cyc();
        inst_addr = 32'h1c00_0008; mem_rdata = 32'ha000_0001;
        settle();
        chk("t1_c2_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_c2_mem_addr", mem_addr, 32'h1c00_0008);
        chk("t1_c2_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_c2_rdata", inst_rdata, 32'ha000_0001);
        cyc();
        inst_req = 1'b0; mem_rdata = 32'ha000_0002;
        settle();
        chk("t1_c3_mem_req", 32'(mem_req), 32'd0);
        chk("t1_c3_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_c3_rdata", inst_rdata, 32'ha000_0002);
        chk("t1_c3_ddata_ok", 32'(data_data_ok), 32'd0);
        cyc();
        mem_data_ok = 1'b0;

        // Both requesting: data, inst, data, inst; responses follow issue order
        inst_req = 1'b1; data_req = 1'b1;
        inst_addr = 32'h1c00_0100; data_addr = 32'h8000_0100;
        settle();
        chk("t2_c0_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("t2_c0_mem_addr", mem_addr, 32'h8000_0100);
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'hb000_0000;
        settle();
        chk("t2_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t2_c1_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("t2_c1_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t2_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
        cyc();
        settle();
        chk("t2_c2_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_c2_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t2_c2_data_data_ok", 32'(data_data_ok), 32'd0);
        cyc();
        settle();
        chk("t2_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t2_c3_data_data_ok", 32'(data_data_ok), 32'd1);
        cyc();
        inst_req = 1'b0; data_req = 1'b0;
        settle();
        chk("t2_c4_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t2_c4_data_data_ok", 32'(data_data_ok), 32'd0);
        cyc();
        mem_data_ok = 1'b0;

        // Stalled data write locks the port against a later inst request
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3;
        data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
        inst_addr = 32'h1c00_0200; mem_addr_ok = 1'b0;
        settle();
        chk("t3_c0_mem_req", 32'(mem_req), 32'd1);
        chk("t3_c0_mem_addr", mem_addr, 32'h8000_0010);
        chk("t3_c0_data_addr_ok", 32'(data_addr_ok), 32'd0);
        cyc();
        inst_req = 1'b1;
        settle();
        chk("t3_c1_mem_addr", mem_addr, 32'h8000_0010);
        chk("t3_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        cyc();
        settle();
        chk("t3_c2_mem_addr", mem_addr, 32'h8000_0010);
        chk("t3_c2_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("t3_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        cyc();
        mem_addr_ok = 1'b1;
        settle();
        chk("t3_c3_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t3_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("t3_c3_mem_wr", 32'(mem_wr), 32'd1);
        chk("t3_c3_mem_size", 32'(mem_size), 32'd1);
        chk("t3_c3_mem_wstrb", 32'(mem_wstrb), 32'h3);
        cyc();
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf;
        settle();
        chk("t3_c4_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t3_c4_mem_addr", mem_addr, 32'h1c00_0200);
        cyc();

        // Two in flight (data, inst): third request stalls until a response frees a slot
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0020;
        settle();
        chk("t4_full_mem_req", 32'(mem_req), 32'd0);
        chk("t4_full_data_addr_ok", 32'(data_addr_ok), 32'd0);
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'hc000_0000;
        settle();
        chk("t4_pop_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t4_pop_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("t4_pop_data_rdata", data_rdata, 32'hc000_0000);
        chk("t4_pop_mem_req", 32'(mem_req), 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t4_after_mem_req", 32'(mem_req), 32'd1);
        chk("t4_after_data_addr_ok", 32'(data_addr_ok), 32'd1);
        cyc();
        data_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hc000_0001;
        settle();
        chk("t4_drain1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t4_drain1_data_data_ok", 32'(data_data_ok), 32'd0);
        cyc();
        mem_rdata = 32'hc000_0002;
        settle();
        chk("t4_drain2_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t4_drain2_inst_data_ok", 32'(inst_data_ok), 32'd0);
        cyc();
        mem_data_ok = 1'b0;

        // Reset with inst then data in flight; late responses flag an error
        inst_req = 1'b1; inst_addr = 32'h1c00_0300;
        settle();
        chk("t5_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0300;
        settle();
        chk("t5_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t5_arb_err_pre", 32'(arb_err), 32'd0);
        cyc();
        data_req = 1'b0; resetn = 1'b0;
        settle();
        chk("t5_rst_mem_req", 32'(mem_req), 32'd0);
        cyc();
        resetn = 1'b1; mem_data_ok = 1'b1;
        settle();
        chk("t5_late1_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("t5_late1_data_data_ok", 32'(data_data_ok), 32'd0);
        cyc();
        settle();
        chk("t5_late2_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("t5_late2_data_data_ok", 32'(data_data_ok), 32'd0);
        chk("t5_arb_err_set", 32'(arb_err), 32'd1);
        cyc();
        mem_data_ok = 1'b0;
        cyc();
        chk("t5_arb_err_sticky", 32'(arb_err), 32'd1);
        resetn = 1'b0;
        cyc();
        chk("t5_arb_err_cleared", 32'(arb_err), 32'd0);
        resetn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-to-one arbiter that lets the instruction-fetch and data-access SRAM-like request ports of the CPU core share a single downstream SRAM-like memory port. Each upstream port uses the req / addr_ok / data_ok handshake. Sits between the IF/EXE memory interfaces and the memory or bridge. It tracks up to OUTSTANDING in-flight transactions so that each in-order response is routed back to the requester that issued it.

## Interface
- OUTSTANDING, 2: maximum accepted-but-unanswered transactions (1..4); depth of the ID FIFO.
- clk  input  1  sole clock, rising edge.
- resetn  input  1  reset, synchronous, active-low.
- inst_req / data_req  input  1  request valid; held by requester until addr_ok.
- inst_wr / data_wr  input  1  1 = write.
- inst_size / data_size  input  2  0 = byte, 1 = half, 2 = word.
- inst_wstrb / data_wstrb  input  4  byte enables.
- inst_addr / data_addr  input  32  byte address.
- inst_wdata / data_wdata  input  32  write data.
- inst_addr_ok / data_addr_ok  output  1  request accepted this cycle.
- inst_data_ok / data_data_ok  output  1  response for oldest own transaction this cycle.
- inst_rdata / data_rdata  output  32  read data; both driven from mem_rdata.
- mem_req, mem_wr, mem_size[1:0], mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  output  downstream request, muxed from the granted requester.
- mem_addr_ok, mem_data_ok  input  1  downstream handshakes; responses return in issue order.
- mem_rdata  input  32  downstream read data.
- arb_err  output  1  sticky; set when mem_data_ok arrives with no outstanding transaction.

## Operation
- State: lock (1b), lock_id (1b), last_grant (1b, 0 = inst, 1 = data), ID FIFO (OUTSTANDING entries × 1b, plus a count), arb_err.
- full = (count == OUTSTANDING). empty = (count == 0). Both come from registered count only.
- Grant selection when lock = 0:
  - Only one requester asserting: that requester.
  - Both asserting: data wins unless last_grant = data, in which case inst wins. This is round-robin on conflict.
- Grant when lock = 1: lock_id, regardless of the other request.
- mem_req = resetn & ~full & (granted requester's req). The payload is a combinational mux of the granted port.
- X_addr_ok = mem_req & mem_addr_ok & (grant == X). The non-granted port's addr_ok is 0.
- Lock rules:
  - Cycle with mem_req & ~mem_addr_ok: next lock = 1, lock_id = grant.
  - Cycle with a handshake (mem_req & mem_addr_ok): next lock = 0.
  - Lock keeps the downstream request stable until acceptance.
- On handshake: push the grant ID into the FIFO and set last_grant = grant.
- On mem_data_ok with ~empty: pop the head ID and assert X_data_ok for X == head, combinationally in the same cycle.
- On mem_data_ok with empty: no upstream data_ok; arb_err <= 1.
- Push and pop in the same cycle: count unchanged, FIFO advances.
- When full, no push occurs even if a pop happens that cycle. mem_req stays low for that cycle.
- A requester that drops req while locked violates the protocol. Behaviour is then undefined except that lock clears when granted req = 0 and mem_req = 0.

## Timing
- Request path has zero-cycle latency: upstream req to mem_req, and mem_addr_ok to X_addr_ok, are combinational.
- Response path has zero-cycle latency: mem_data_ok/mem_rdata to X_data_ok/X_rdata are combinational.
- Registered state updates on the rising clk edge.
- Reset (resetn = 0 sampled at an edge): count = 0, lock = 0, last_grant = 0, arb_err = 0.
- Outputs while resetn = 0:
  - mem_req = 0.
  - All addr_ok and data_ok outputs = 0.
  - Other outputs follow the mux and are don't-care.
- Reset mid-operation discards all outstanding IDs. Late mem_data_ok after reset, with the FIFO empty, sets arb_err.
- Throughput: one handshake per cycle while ~full.
- With OUTSTANDING = 2 and a 1-cycle-response memory, back-to-back requests sustain 1 per cycle.

## Test plan
- Inst-only reads, mem_addr_ok = 1 always, data_ok one cycle after each accept, inst_addr = 0x1c000000, 0x1c000004, 0x1c000008 -> inst_addr_ok high each cycle; three inst_data_ok pulses return the mem_rdata values in order; data_data_ok never asserts.
- inst_req and data_req both held high for 4 cycles, mem_addr_ok = 1 -> grant sequence data, inst, data, inst; last_grant alternates.
- data_req with mem_addr_ok = 0 for 3 cycles, inst_req raised in cycle 2 -> mem_addr and data_addr stay stable for all 3 cycles; inst_addr_ok = 0 until the data handshake.
- OUTSTANDING = 2, mem_data_ok withheld after 2 accepts -> mem_req = 0 with a third request pending. Then one mem_data_ok -> data_ok routed to the first issuer; mem_req rises the next cycle.
- Two transactions in flight (inst, then data), resetn low for 1 cycle, then mem_data_ok pulses -> no upstream data_ok; arb_err = 1 until the next reset.
- Same-cycle push and pop with count = 1: count remains 1; the pop goes to the old head, the push becomes the new head.
